shift_row: RTL and testbench

AES ShiftRows / InvShiftRows byte-permutation stage for the round datapath. It takes one 128-bit state per cycle and applies the forward (encrypt) or inverse (decrypt) row rotation. The result is registered, with one cycle of latency. It sits between SubBytes/InvSubBytes and MixColumns/AddRoundKey in the round pipeline.

---
 rtl/shift_row_pkg.sv | 31 +++
 rtl/shift_row_perm.sv | 16 +
 rtl/shift_row.sv | 40 ++++
 tb/tb_shift_row.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/shift_row_pkg.sv
// Shared AES definitions: the 128-bit state type, byte access helper and the
// ShiftRows / InvShiftRows byte-index maps.
package shift_row_pkg;

    typedef logic [127:0] state_t;

    localparam int NUM_BYTES = 16;

    // Entry k names the input byte that lands in output byte k (byte 0 = MSB byte).
    localparam logic [3:0] SHIFT_ROWS_MAP [NUM_BYTES] = '{
        4'd0,  4'd5,  4'd10, 4'd15,
        4'd4,  4'd9,  4'd14, 4'd3,
        4'd8,  4'd13, 4'd2,  4'd7,
        4'd12, 4'd1,  4'd6,  4'd11
    };

    localparam logic [3:0] INV_SHIFT_ROWS_MAP [NUM_BYTES] = '{
        4'd0,  4'd13, 4'd10, 4'd7,
        4'd4,  4'd1,  4'd14, 4'd11,
        4'd8,  4'd5,  4'd2,  4'd15,
        4'd12, 4'd9,  4'd6,  4'd3
    };

    // Byte idx of the state, counting from the most significant byte.
    function automatic logic [7:0] get_byte(input state_t s, input logic [3:0] idx);
        state_t t;
        t = s << (8 * idx);
        return t[127:120];
    endfunction

endpackage

// File: rtl/shift_row_perm.sv
// Combinational AES row rotation: forward ShiftRows when encrypt=1,
// InvShiftRows otherwise.
module shift_row_perm
    import shift_row_pkg::*;
(
    input  logic   encrypt,
    input  state_t state_in,
    output state_t state_out
);

    for (genvar k = 0; k < NUM_BYTES; k++) begin : g_byte
        assign state_out[127-8*k -: 8] = encrypt ? get_byte(state_in, SHIFT_ROWS_MAP[k])
                                                 : get_byte(state_in, INV_SHIFT_ROWS_MAP[k]);
    end

endmodule

// File: rtl/shift_row.sv
// Registered ShiftRows / InvShiftRows stage of the AES round datapath,
// one state per cycle with one cycle of latency.
module shift_row
    import shift_row_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic         encrypt,
    input  logic [127:0] in_diffusion,
    output logic         out_valid,
    output logic [127:0] shifted
);

    // Valid-only handshake: a state is taken whenever in_valid is high at a
    // rising edge, and its result is presented for exactly one cycle with
    // out_valid high. There is no ready; the consumer must accept it then.

    state_t perm_out;

    shift_row_perm u_perm (
        .encrypt   (encrypt),
        .state_in  (in_diffusion),
        .state_out (perm_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shifted   <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            // Bubbles leave the last result visible on shifted.
            if (in_valid) begin
                shifted <= perm_out;
            end
        end
    end

endmodule

// File: tb/tb_shift_row.sv
// Self-checking bench for shift_row: known vectors, round trip, streaming,
// bubbles and asynchronous reset, with an expected-result queue.
module tb_shift_row;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         encrypt;
    logic [127:0] in_diffusion;
    logic         out_valid;
    logic [127:0] shifted;

    logic [127:0] exp_q[$];
    int           errors;
    int           checks;

    shift_row dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .encrypt      (encrypt),
        .in_diffusion (in_diffusion),
        .out_valid    (out_valid),
        .shifted      (shifted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Golden model written from the row-rotation formula, not the index tables.
    function automatic logic [127:0] model_shift(input logic [127:0] s, input logic enc);
        logic [127:0] o;
        int src_c;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                src_c = enc ? (c + r) % 4 : (c - r + 4) % 4;
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*src_c+r) -: 8];
            end
        end
        return o;
    endfunction

    task automatic drive(input logic v, input logic enc, input logic [127:0] d);
        in_valid     = v;
        encrypt      = enc;
        in_diffusion = d;
        if (v) exp_q.push_back(model_shift(d, enc));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [127:0] exp;
        rst = 1'b1;
        drive(1'b0, 1'b0, '0);
        #2;
        checks++;
        if (shifted !== 128'h0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_initial: shifted=%h out_valid=%b, want 0/0", shifted, out_valid);
        end
        step();
        rst = 1'b0;
        // Put a result in flight, then reset between edges.
        drive(1'b1, 1'b1, 128'h112233445566778899aabbccddeeff00);
        step();
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        checks++;
        if (out_valid !== 1'b1 || shifted !== exp) begin
            errors++;
            $display("FAIL reset_prestream: shifted=%h out_valid=%b, want %h/1", shifted, out_valid, exp);
        end
        drive(1'b1, 1'b0, 128'hdeadbeefcafef00d0123456789abcdef);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (shifted !== 128'h0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: shifted=%h out_valid=%b, want 0/0", shifted, out_valid);
        end
        exp_q.delete();
        step();
        checks++;
        if (shifted !== 128'h0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: shifted=%h out_valid=%b, want 0/0", shifted, out_valid);
        end
        rst = 1'b0;
        drive(1'b1, 1'b1, 128'h0f0e0d0c0b0a09080706050403020100);
        step();
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        checks++;
        if (out_valid !== 1'b1 || shifted !== exp) begin
            errors++;
            $display("FAIL reset_first_after: shifted=%h out_valid=%b, want %h/1", shifted, out_valid, exp);
        end
        drive(1'b0, 1'b0, '0);
        step();
    endtask

    task automatic test_decrypt();
        drive(1'b1, 1'b0, 128'h000102030405060708090a0b0c0d0e0f);
        step();
        void'(exp_q.pop_front());
        checks++;
        if (out_valid !== 1'b1 || shifted !== 128'h000d0a0704010e0b0805020f0c090603) begin
            errors++;
            $display("FAIL decrypt_vector: shifted=%h out_valid=%b, want 000d0a0704010e0b0805020f0c090603/1",
                     shifted, out_valid);
        end
    endtask

    task automatic test_encrypt();
        drive(1'b1, 1'b1, 128'h000102030405060708090a0b0c0d0e0f);
        step();
        void'(exp_q.pop_front());
        checks++;
        if (out_valid !== 1'b1 || shifted !== 128'h00050a0f04090e03080d02070c01060b) begin
            errors++;
            $display("FAIL encrypt_vector: shifted=%h out_valid=%b, want 00050a0f04090e03080d02070c01060b/1",
                     shifted, out_valid);
        end
    endtask

    task automatic test_round_trip();
        logic [127:0] orig;
        logic [127:0] exp;
        orig = 128'h01f21379a3b267342921fa6c2ccc3aef;
        drive(1'b1, 1'b1, orig);
        step();
        exp = exp_q.pop_front();
        checks++;
        if (shifted !== exp) begin
            errors++;
            $display("FAIL round_trip_fwd: shifted=%h, want %h", shifted, exp);
        end
        drive(1'b1, 1'b0, shifted);
        step();
        void'(exp_q.pop_front());
        checks++;
        if (out_valid !== 1'b1 || shifted !== orig) begin
            errors++;
            $display("FAIL round_trip_back: shifted=%h out_valid=%b, want %h/1", shifted, out_valid, orig);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] d;
        logic [127:0] exp;
        for (int i = 0; i < 24; i++) begin
            d = {$urandom(), $urandom(), $urandom(), $urandom()};
            drive(1'b1, (i % 2 == 0), d);
            step();
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b2b_queue_empty: item=%0d", i);
            end else begin
                exp = exp_q.pop_front();
                checks++;
                if (out_valid !== 1'b1 || shifted !== exp) begin
                    errors++;
                    $display("FAIL b2b_item%0d: shifted=%h out_valid=%b, want %h/1", i, shifted, out_valid, exp);
                end
            end
        end
    endtask

    task automatic test_bubble();
        logic [127:0] held;
        logic [127:0] exp;
        drive(1'b1, ($urandom_range(0, 1) == 1), 128'h3243f6a8885a308d313198a2e0370734);
        step();
        held = exp_q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || shifted !== held) begin
            errors++;
            $display("FAIL bubble_before: shifted=%h out_valid=%b, want %h/1", shifted, out_valid, held);
        end
        drive(1'b0, 1'b1, 128'hffffffffffffffffffffffffffffffff);
        step();
        checks++;
        if (out_valid !== 1'b0 || shifted !== held) begin
            errors++;
            $display("FAIL bubble_gap: shifted=%h out_valid=%b, want %h/0", shifted, out_valid, held);
        end
        drive(1'b1, 1'b0, 128'h00112233445566778899aabbccddeeff);
        step();
        exp = exp_q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || shifted !== exp) begin
            errors++;
            $display("FAIL bubble_after: shifted=%h out_valid=%b, want %h/1", shifted, out_valid, exp);
        end
        drive(1'b0, 1'b0, '0);
        step();
        checks++;
        if (out_valid !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL bubble_drain: out_valid=%b queue=%0d, want 0/0", out_valid, exp_q.size());
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_decrypt();
        test_encrypt();
        test_round_trip();
        test_back_to_back();
        test_bubble();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
